// File: rtl/cdc_fifo_pkg.sv
// Shared constants and Gray-code helpers for both sides of the CDC FIFO.
package cdc_fifo_pkg;

  localparam int PTR_WIDTH  = 4;
  localparam int FIFO_DEPTH = 8;

  typedef logic [PTR_WIDTH-1:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return bin ^ (bin >> 1);
  endfunction

  // Each binary bit is the XOR of all Gray bits at or above its position.
  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    for (int i = 0; i < PTR_WIDTH; i++) begin
      bin[i] = ^(gray >> i);
    end
    return bin;
  endfunction

endpackage

// File: rtl/read_control_logic_if.sv
// Read-side FIFO bus: consumer/synchronizer on the master side, read control on the slave side.
interface read_control_logic_if #(
  parameter int PTR_WIDTH = cdc_fifo_pkg::PTR_WIDTH
);

  logic                 read_enable;
  logic [PTR_WIDTH-1:0] w_synchronization;
  logic                 empty;
  logic [PTR_WIDTH-1:0] read_addr_out;
  logic                 read_enable_out;
  logic [PTR_WIDTH-1:0] read_addr_gray;
  logic [PTR_WIDTH-1:0] read_level;

  modport master (
    output read_enable, w_synchronization,
    input  empty, read_addr_out, read_enable_out, read_addr_gray, read_level
  );

  modport slave (
    input  read_enable, w_synchronization,
    output empty, read_addr_out, read_enable_out, read_addr_gray, read_level
  );

endinterface

// File: rtl/gray_to_binary.sv
// Combinational Gray-to-binary decoder, shared by the read-empty and write-full logic.
module gray_to_binary #(
  parameter int WIDTH = cdc_fifo_pkg::PTR_WIDTH
) (
  input  logic [WIDTH-1:0] gray,
  output logic [WIDTH-1:0] bin
);

  // Per-bit XOR reduction keeps every output bit independent of the others.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign bin[gi] = ^(gray >> gi);
  end

endmodule

// File: rtl/read_control_logic.sv
// Read-domain pointer, empty flag and occupancy for the CDC FIFO; pops are gated by the registered empty.
module read_control_logic #(
  parameter int PTR_WIDTH = cdc_fifo_pkg::PTR_WIDTH
) (
  input  logic                 read_clk,
  input  logic                 read_rst,
  read_control_logic_if.slave  bus
);

  logic [PTR_WIDTH-1:0] read_pointer_reg, read_pointer_next;
  logic [PTR_WIDTH-1:0] read_addr_reg, read_addr_next;
  logic [PTR_WIDTH-1:0] read_gray_reg, read_gray_next;
  logic [PTR_WIDTH-1:0] read_level_reg, read_level_next;
  logic                 read_strobe_reg, read_strobe_next;
  logic                 empty_reg, empty_next;
  logic [PTR_WIDTH-1:0] wp_bin;
  logic                 pop;

  gray_to_binary #(.WIDTH(PTR_WIDTH)) u_wp_decode (
    .gray (bus.w_synchronization),
    .bin  (wp_bin)
  );

  // Empty and level always track the live write pointer, with or without a pop.
  always_comb begin
    pop               = bus.read_enable && !empty_reg;
    read_pointer_next = pop ? read_pointer_reg + PTR_WIDTH'(1) : read_pointer_reg;
    read_addr_next    = pop ? read_pointer_reg : read_addr_reg;
    read_strobe_next  = pop;
    read_gray_next    = read_pointer_next ^ (read_pointer_next >> 1);
    empty_next        = (read_pointer_next == wp_bin);
    read_level_next   = wp_bin - read_pointer_next;
  end

  always_ff @(posedge read_clk) begin
    if (read_rst) begin
      read_pointer_reg <= '0;
      read_addr_reg    <= '0;
      read_gray_reg    <= '0;
      read_level_reg   <= '0;
      read_strobe_reg  <= 1'b0;
      empty_reg        <= 1'b1;
    end else begin
      assert (read_level_next <= PTR_WIDTH'(cdc_fifo_pkg::FIFO_DEPTH));
      read_pointer_reg <= read_pointer_next;
      read_addr_reg    <= read_addr_next;
      read_gray_reg    <= read_gray_next;
      read_level_reg   <= read_level_next;
      read_strobe_reg  <= read_strobe_next;
      empty_reg        <= empty_next;
    end
  end

  assign bus.empty           = empty_reg;
  assign bus.read_addr_out   = read_addr_reg;
  assign bus.read_enable_out = read_strobe_reg;
  assign bus.read_addr_gray  = read_gray_reg;
  assign bus.read_level      = read_level_reg;

endmodule
